// File: rtl/ysyx_22041412_axi_arb_pkg.sv
// rtl/ysyx_22041412_axi_arb_pkg.sv - shared types, constants and helpers for the AXI request arbiter
// Contents: channel FSM state type, arbitration mode constants, clog2 helper (minimum 1).
package ysyx_22041412_axi_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Pointer width; never below 1 so a 1-bit pointer still exists for tiny configs.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ysyx_22041412_rr_pick.sv
// rtl/ysyx_22041412_rr_pick.sv - one-hot request picker, round-robin from a base pointer or fixed priority
// Ports: req (request vector), base (round-robin start index), rr_mode (1 = round-robin,
//        0 = lowest index wins), grant (one-hot, zero when no request).
module ysyx_22041412_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] base,
    input  logic          rr_mode,
    output logic [N-1:0]  grant
);

    int   start;
    int   pos;
    logic found;

    // Walk positions start, start+1, ... wrapping at N; the first requester found wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        start = rr_mode ? int'(base) : 0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = start + k;
            if (pos >= N) pos = pos - N;
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == pos)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_axi_rr_arbiter.sv
// rtl/ysyx_22041412_axi_rr_arbiter.sv - N-master read/write arbiter in front of the AXI master bridge
// Ports: clk, rst (async, active-high); per-master request bus m_valid/m_wen/m_addr/m_wdata/m_len/m_size
//        and response m_ready/m_rdata/m_last; bridge read side r_*/data_read_o, write side w_*/rw_w_data_i;
//        status rd_busy/wr_busy and sticky burst-length error flags rd_len_err/wr_len_err.
module ysyx_22041412_axi_rr_arbiter
    import ysyx_22041412_axi_arb_pkg::*;
#(
    parameter int NUM_MST        = 2,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ARB_MODE       = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MST-1:0]                  m_valid,
    input  logic [NUM_MST-1:0]                  m_wen,
    input  logic [NUM_MST*AXI_ADDR_WIDTH-1:0]   m_addr,
    input  logic [NUM_MST*AXI_DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_MST*8-1:0]                m_len,
    input  logic [NUM_MST*8-1:0]                m_size,
    output logic [NUM_MST-1:0]                  m_ready,
    output logic [NUM_MST*AXI_DATA_WIDTH-1:0]   m_rdata,
    output logic [NUM_MST-1:0]                  m_last,
    output logic                                r_valid_i,
    output logic [AXI_ADDR_WIDTH-1:0]           r_addr_i,
    output logic [7:0]                          r_size_i,
    output logic [7:0]                          r_len_i,
    output logic                                w_valid_i,
    output logic [AXI_ADDR_WIDTH-1:0]           w_addr_i,
    output logic [AXI_DATA_WIDTH-1:0]           rw_w_data_i,
    output logic [7:0]                          w_size_i,
    output logic [7:0]                          w_len_i,
    input  logic                                r_ready_o,
    input  logic                                r_last_i,
    input  logic [AXI_DATA_WIDTH-1:0]           data_read_o,
    input  logic                                w_ready_o,
    input  logic                                w_last_i,
    output logic                                rd_busy,
    output logic                                wr_busy,
    output logic                                rd_len_err,
    output logic                                wr_len_err
);

    localparam int PW = clog2_min1(NUM_MST);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;

    // Channel index 0 = read, 1 = write; both channels share one FSM description.
    arb_state_e          state_q [2];
    arb_state_e          state_d [2];
    logic [NUM_MST-1:0]  grant_q [2];
    logic [NUM_MST-1:0]  grant_d [2];
    logic [PW-1:0]       ptr_q   [2];
    logic [PW-1:0]       ptr_d   [2];
    logic [7:0]          cnt_q   [2];
    logic [7:0]          cnt_d   [2];
    logic                err_q   [2];
    logic                err_d   [2];

    logic [NUM_MST-1:0]  cand     [2];
    logic [NUM_MST-1:0]  pick     [2];
    logic                ch_ready [2];
    logic                ch_last  [2];
    logic                g_ok     [2];
    logic [PW-1:0]       g_idx    [2];
    logic [PW-1:0]       ptr_next [2];
    logic [AW-1:0]       g_addr   [2];
    logic [7:0]          g_len    [2];
    logic [7:0]          g_size   [2];
    logic [DW-1:0]       g_wdata;

    assign cand[0]     = m_valid & ~m_wen;
    assign cand[1]     = m_valid & m_wen;
    assign ch_ready[0] = r_ready_o;
    assign ch_ready[1] = w_ready_o;
    assign ch_last[0]  = r_last_i;
    assign ch_last[1]  = w_last_i;

    for (genvar c = 0; c < 2; c++) begin : g_pick
        ysyx_22041412_rr_pick #(
            .N  (NUM_MST),
            .PW (PW)
        ) u_pick (
            .req     (cand[c]),
            .base    (ptr_q[c]),
            .rr_mode (ARB_MODE == ARB_RR),
            .grant   (pick[c])
        );
    end

    // Grant is one-hot (or zero outside BUSY), so an AND-OR mux suffices and yields 0 when idle.
    always_comb begin
        g_wdata = '0;
        for (int c = 0; c < 2; c++) begin
            g_addr[c] = '0;
            g_len[c]  = '0;
            g_size[c] = '0;
            g_idx[c]  = '0;
            for (int i = 0; i < NUM_MST; i++) begin
                if (grant_q[c][i]) begin
                    g_addr[c] = g_addr[c] | m_addr[i*AW +: AW];
                    g_len[c]  = g_len[c]  | m_len[i*8 +: 8];
                    g_size[c] = g_size[c] | m_size[i*8 +: 8];
                    g_idx[c]  = g_idx[c]  | PW'(i);
                end
            end
            // Granted master still asking for this channel; false means cancel.
            g_ok[c]     = |(grant_q[c] & cand[c]);
            ptr_next[c] = (int'(g_idx[c]) == NUM_MST - 1) ? '0 : g_idx[c] + PW'(1);
        end
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_q[1][i]) g_wdata = g_wdata | m_wdata[i*DW +: DW];
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            grant_d[c] = grant_q[c];
            ptr_d[c]   = ptr_q[c];
            cnt_d[c]   = cnt_q[c];
            err_d[c]   = err_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (|cand[c]) begin
                        grant_d[c] = pick[c];
                        cnt_d[c]   = '0;
                        state_d[c] = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!g_ok[c]) begin
                        // Master withdrew mid-burst: release without length check.
                        grant_d[c] = '0;
                        ptr_d[c]   = ptr_next[c];
                        cnt_d[c]   = '0;
                        state_d[c] = ST_IDLE;
                    end else if (ch_ready[c]) begin
                        if (ch_last[c]) begin
                            if (cnt_q[c] != g_len[c]) err_d[c] = 1'b1;
                            grant_d[c] = '0;
                            ptr_d[c]   = ptr_next[c];
                            cnt_d[c]   = '0;
                            state_d[c] = ST_IDLE;
                        end else begin
                            cnt_d[c] = cnt_q[c] + 8'd1;
                        end
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= ST_IDLE;
                grant_q[c] <= '0;
                ptr_q[c]   <= '0;
                cnt_q[c]   <= '0;
                err_q[c]   <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                grant_q[c] <= grant_d[c];
                ptr_q[c]   <= ptr_d[c];
                cnt_q[c]   <= cnt_d[c];
                err_q[c]   <= err_d[c];
            end
        end
    end

    always_comb begin
        m_ready = '0;
        m_last  = '0;
        m_rdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            m_ready[i] = (grant_q[0][i] & r_ready_o) | (grant_q[1][i] & w_ready_o);
            m_last[i]  = (grant_q[0][i] & r_last_i)  | (grant_q[1][i] & w_last_i);
            if (grant_q[0][i]) m_rdata[i*DW +: DW] = data_read_o;
        end
    end

    assign r_valid_i   = g_ok[0];
    assign r_addr_i    = g_addr[0];
    assign r_size_i    = g_size[0];
    assign r_len_i     = g_len[0];
    assign w_valid_i   = g_ok[1];
    assign w_addr_i    = g_addr[1];
    assign rw_w_data_i = g_wdata;
    assign w_size_i    = g_size[1];
    assign w_len_i     = g_len[1];
    assign rd_busy     = (state_q[0] == ST_BUSY);
    assign wr_busy     = (state_q[1] == ST_BUSY);
    assign rd_len_err  = err_q[0];
    assign wr_len_err  = err_q[1];

endmodule

// File: tb/tb_ysyx_22041412_axi_rr_arbiter.sv
// tb/tb_ysyx_22041412_axi_rr_arbiter.sv - directed bench for the N-master AXI request arbiter
module tb_ysyx_22041412_axi_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   m_valid, m_wen;
    logic [95:0]  m_addr;
    logic [191:0] m_wdata;
    logic [23:0]  m_len, m_size;
    logic         r_ready_o, r_last_i, w_ready_o, w_last_i;
    logic [63:0]  data_read_o;

    logic [2:0]   m_ready, m_last;
    logic [191:0] m_rdata;
    logic         r_valid_i, w_valid_i, rd_busy, wr_busy, rd_len_err, wr_len_err;
    logic [31:0]  r_addr_i, w_addr_i;
    logic [63:0]  rw_w_data_i;
    logic [7:0]   r_size_i, r_len_i, w_size_i, w_len_i;

    logic [2:0]   f_m_ready, f_m_last;
    logic [191:0] f_m_rdata;
    logic         f_r_valid_i, f_w_valid_i, f_rd_busy, f_wr_busy, f_rd_len_err, f_wr_len_err;
    logic [31:0]  f_r_addr_i, f_w_addr_i;
    logic [63:0]  f_rw_w_data_i;
    logic [7:0]   f_r_size_i, f_r_len_i, f_w_size_i, f_w_len_i;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000, A2 = 32'h3000_0000;
    localparam logic [63:0] D0 = 64'hAAAA_0000_0000_0001, D1 = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] D2 = 64'hCCCC_0000_0000_0003, RD = 64'hDEAD_BEEF_0123_4567;

    always #5 clk = ~clk;

    ysyx_22041412_axi_rr_arbiter #(
        .NUM_MST(3), .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .ARB_MODE(1)
    ) dut_rr (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_len(m_len), .m_size(m_size), .m_ready(m_ready),
        .m_rdata(m_rdata), .m_last(m_last), .r_valid_i(r_valid_i), .r_addr_i(r_addr_i),
        .r_size_i(r_size_i), .r_len_i(r_len_i), .w_valid_i(w_valid_i), .w_addr_i(w_addr_i),
        .rw_w_data_i(rw_w_data_i), .w_size_i(w_size_i), .w_len_i(w_len_i),
        .r_ready_o(r_ready_o), .r_last_i(r_last_i), .data_read_o(data_read_o),
        .w_ready_o(w_ready_o), .w_last_i(w_last_i), .rd_busy(rd_busy), .wr_busy(wr_busy),
        .rd_len_err(rd_len_err), .wr_len_err(wr_len_err)
    );

    ysyx_22041412_axi_rr_arbiter #(
        .NUM_MST(3), .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .ARB_MODE(0)
    ) dut_fx (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_len(m_len), .m_size(m_size), .m_ready(f_m_ready),
        .m_rdata(f_m_rdata), .m_last(f_m_last), .r_valid_i(f_r_valid_i), .r_addr_i(f_r_addr_i),
        .r_size_i(f_r_size_i), .r_len_i(f_r_len_i), .w_valid_i(f_w_valid_i), .w_addr_i(f_w_addr_i),
        .rw_w_data_i(f_rw_w_data_i), .w_size_i(f_w_size_i), .w_len_i(f_w_len_i),
        .r_ready_o(r_ready_o), .r_last_i(r_last_i), .data_read_o(data_read_o),
        .w_ready_o(w_ready_o), .w_last_i(w_last_i), .rd_busy(f_rd_busy), .wr_busy(f_wr_busy),
        .rd_len_err(f_rd_len_err), .wr_len_err(f_wr_len_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_valid = '0; m_wen = '0; m_len = '0;
        r_ready_o = 1'b0; r_last_i = 1'b0; w_ready_o = 1'b0; w_last_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_valid = 3'b111; m_wen = 3'b010; r_ready_o = 1'b1; w_ready_o = 1'b1; r_last_i = 1'b1;
        #1;
        n_vec++; if (m_ready !== 3'b000) begin $display("FAIL reset_m_ready got %b exp 000", m_ready); n_err++; end
        n_vec++; if (r_valid_i !== 1'b0) begin $display("FAIL reset_r_valid got %b exp 0", r_valid_i); n_err++; end
        n_vec++; if (w_valid_i !== 1'b0) begin $display("FAIL reset_w_valid got %b exp 0", w_valid_i); n_err++; end
        tick();
        n_vec++; if ({rd_busy, wr_busy} !== 2'b00) begin $display("FAIL reset_busy got %b exp 00", {rd_busy, wr_busy}); n_err++; end
        n_vec++; if ({rd_len_err, wr_len_err} !== 2'b00) begin $display("FAIL reset_err got %b exp 00", {rd_len_err, wr_len_err}); n_err++; end
        n_vec++; if (r_addr_i !== 32'h0) begin $display("FAIL reset_r_addr got %h exp 0", r_addr_i); n_err++; end
        n_vec++; if (m_rdata !== 192'h0) begin $display("FAIL reset_m_rdata got %h exp 0", m_rdata); n_err++; end
        n_vec++; if (m_last !== 3'b000) begin $display("FAIL reset_m_last got %b exp 000", m_last); n_err++; end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_rr_order();
        logic [2:0] exp_rdy [7];
        exp_rdy = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        apply_reset();
        m_valid = 3'b111; m_wen = 3'b000; m_len = '0; r_ready_o = 1'b1; r_last_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_vec++; if (m_ready !== exp_rdy[k]) begin $display("FAIL rr_order_c%0d got %b exp %b", k, m_ready, exp_rdy[k]); n_err++; end
            if (k == 0) begin
                n_vec++; if (r_addr_i !== A0) begin $display("FAIL rr_first_addr got %h exp %h", r_addr_i, A0); n_err++; end
                n_vec++; if (m_rdata !== {128'h0, RD}) begin $display("FAIL rr_rdata got %h exp %h", m_rdata, {128'h0, RD}); n_err++; end
            end
            if (k == 1) begin
                n_vec++; if (r_valid_i !== 1'b0) begin $display("FAIL rr_bubble_valid got %b exp 0", r_valid_i); n_err++; end
            end
        end
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        logic [2:0] exp;
        apply_reset();
        m_valid = 3'b101; m_wen = 3'b000; m_len = '0; r_ready_o = 1'b1; r_last_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp = (k % 2 == 0) ? 3'b001 : 3'b000;
            n_vec++; if (f_m_ready !== exp) begin $display("FAIL fixed_c%0d got %b exp %b", k, f_m_ready, exp); n_err++; end
        end
        clear_inputs();
    endtask

    task automatic test_concurrent();
        int rbeats, wbeats;
        rbeats = 0; wbeats = 0;
        apply_reset();
        m_valid = 3'b011; m_wen = 3'b001; m_len = {8'd0, 8'd3, 8'd1};
        r_ready_o = 1'b1; w_ready_o = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            r_last_i = (k == 4);
            w_last_i = (k == 2);
            if (k == 3) m_valid[0] = 1'b0;
            if (k == 5) m_valid[1] = 1'b0;
            #1;
            rbeats += int'(m_ready[1]);
            wbeats += int'(m_ready[0]);
            if (k == 1) begin
                n_vec++; if ({rd_busy, wr_busy} !== 2'b11) begin $display("FAIL conc_busy got %b exp 11", {rd_busy, wr_busy}); n_err++; end
                n_vec++; if (r_addr_i !== A1 || r_len_i !== 8'd3 || r_size_i !== 8'h02) begin $display("FAIL conc_rd_bus got %h/%0d/%h exp %h/3/02", r_addr_i, r_len_i, r_size_i, A1); n_err++; end
                n_vec++; if (w_addr_i !== A0 || w_len_i !== 8'd1 || rw_w_data_i !== D0) begin $display("FAIL conc_wr_bus got %h/%0d/%h exp %h/1/%h", w_addr_i, w_len_i, rw_w_data_i, A0, D0); n_err++; end
            end
        end
        n_vec++; if (rbeats != 4) begin $display("FAIL conc_rd_beats got %0d exp 4", rbeats); n_err++; end
        n_vec++; if (wbeats != 2) begin $display("FAIL conc_wr_beats got %0d exp 2", wbeats); n_err++; end
        n_vec++; if ({rd_len_err, wr_len_err} !== 2'b00) begin $display("FAIL conc_no_err got %b exp 00", {rd_len_err, wr_len_err}); n_err++; end
        clear_inputs();
    endtask

    task automatic test_len_err();
        apply_reset();
        m_valid = 3'b001; m_wen = 3'b000; m_len = {8'd0, 8'd0, 8'd3}; r_ready_o = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            r_last_i = (k == 3);
        end
        m_valid = 3'b000; r_last_i = 1'b0;
        n_vec++; if (rd_len_err !== 1'b1) begin $display("FAIL len_err_set got %b exp 1", rd_len_err); n_err++; end
        m_valid = 3'b001; m_len = '0; r_last_i = 1'b1;
        tick();
        tick();
        m_valid = 3'b000;
        tick();
        n_vec++; if (rd_len_err !== 1'b1) begin $display("FAIL len_err_sticky got %b exp 1", rd_len_err); n_err++; end
        n_vec++; if (wr_len_err !== 1'b0) begin $display("FAIL len_err_wr got %b exp 0", wr_len_err); n_err++; end
        clear_inputs();
    endtask

    task automatic test_cancel();
        apply_reset();
        m_valid = 3'b001; m_wen = 3'b000; m_len = {8'd0, 8'd0, 8'd7}; r_ready_o = 1'b1;
        tick();
        tick();
        m_valid = 3'b000;
        #1;
        n_vec++; if (r_valid_i !== 1'b0) begin $display("FAIL cancel_r_valid got %b exp 0", r_valid_i); n_err++; end
        tick();
        n_vec++; if (rd_busy !== 1'b0) begin $display("FAIL cancel_idle got %b exp 0", rd_busy); n_err++; end
        n_vec++; if (rd_len_err !== 1'b0) begin $display("FAIL cancel_no_err got %b exp 0", rd_len_err); n_err++; end
        m_valid = 3'b011; m_len = '0; r_ready_o = 1'b0;
        tick();
        n_vec++; if (r_addr_i !== A1) begin $display("FAIL cancel_ptr got %h exp %h", r_addr_i, A1); n_err++; end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_valid = 3'b010; m_wen = 3'b000; m_len = '0; r_ready_o = 1'b1; r_last_i = 1'b1;
        tick();
        tick();
        m_valid = 3'b001; m_len = {8'd0, 8'd0, 8'd7}; r_last_i = 1'b0;
        tick();
        tick();
        n_vec++; if (r_addr_i !== A0) begin $display("FAIL mid_pre_grant got %h exp %h", r_addr_i, A0); n_err++; end
        rst = 1'b1;
        #1;
        n_vec++; if (m_ready !== 3'b000) begin $display("FAIL mid_m_ready got %b exp 000", m_ready); n_err++; end
        n_vec++; if (r_valid_i !== 1'b0 || rd_busy !== 1'b0) begin $display("FAIL mid_valid_busy got %b%b exp 00", r_valid_i, rd_busy); n_err++; end
        n_vec++; if (r_addr_i !== 32'h0 || m_rdata !== 192'h0) begin $display("FAIL mid_bus got %h/%h exp 0/0", r_addr_i, m_rdata); n_err++; end
        #1;
        m_valid = 3'b110; m_len = '0;
        rst = 1'b0;
        tick();
        n_vec++; if (r_addr_i !== A1) begin $display("FAIL mid_rr_first got %h exp %h", r_addr_i, A1); n_err++; end
        n_vec++; if (m_ready !== 3'b010) begin $display("FAIL mid_rr_ready got %b exp 010", m_ready); n_err++; end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        m_addr = {A2, A1, A0};
        m_wdata = {D2, D1, D0};
        m_size = {8'h01, 8'h02, 8'h03};
        data_read_o = RD;
        clear_inputs();
        test_reset();
        test_rr_order();
        test_fixed_priority();
        test_concurrent();
        test_len_err();
        test_cancel();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
